// File: rtl/ifu_pkg.sv
`default_nettype none
// +---------------------------------------------------------------+
// | ifu_pkg -- shared types and constants for the fetch unit       |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
package ifu_pkg;

  localparam int          ILEN_BYTES     = 4;
  localparam logic [31:0] RST_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } ibuf_ent_t;

endpackage
`default_nettype wire

// File: rtl/ifu_if.sv
`default_nettype none
// +---------------------------------------------------------------+
// | ifetch_if_t / iexec_if_t -- fetch-memory and fetch-execute buses |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
interface ifetch_if_t #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_addr;
  logic          rsp_vld;
  logic [DW-1:0] rsp_data;

  modport master (output req_vld, req_addr, input req_rdy, rsp_vld, rsp_data);
  modport slave  (input req_vld, req_addr, output req_rdy, rsp_vld, rsp_data);
endinterface

interface iexec_if_t #(
  parameter int AW = 32,
  parameter int DW = 32
);
  typedef struct packed {
    logic [DW-1:0] ir;
    logic [AW-1:0] pc;
  } req_pkt_t;

  typedef struct packed {
    logic          taken;
    logic [AW-1:0] offset;
  } rsp_pkt_t;

  logic     req_vld;
  logic     req_rdy;
  req_pkt_t req_pkt;
  rsp_pkt_t rsp_pkt;

  modport master (output req_vld, req_pkt, input req_rdy, rsp_pkt);
  modport slave  (input req_vld, req_pkt, output req_rdy, rsp_pkt);
endinterface
`default_nettype wire

// File: rtl/ifu_ibuf.sv
`default_nettype none
// +---------------------------------------------------------------+
// | ifu_ibuf -- two-entry in-order instruction buffer, flush wins  |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
module ifu_ibuf
  import ifu_pkg::*;
#(
  parameter type ENT_T = ibuf_ent_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  ENT_T       push_ent_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output ENT_T       head_o,
  output logic [1:0] occ_o
);

  ENT_T       mem_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] occ_q, occ_d;
  logic       do_push, do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & (occ_q != 2'd0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      occ_d = occ_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      if (do_push) mem_q[wr_ptr_q] <= push_ent_i;
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// +---------------------------------------------------------------+
// | ifu -- instruction fetch unit: PC, one-deep fetch, redirects   |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
module ifu
  import ifu_pkg::*;
#(
  parameter int            AW     = 32,
  parameter int            DW     = 32,
  parameter logic [AW-1:0] RST_PC = AW'(RST_PC_DEFAULT)
) (
  input  logic       clk,
  input  logic       rst,
  ifetch_if_t.master ifetch,
  iexec_if_t.master  iexec
);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
  } ent_t;

  ifu_state_e    state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] out_pc_q, out_pc_d;

  ent_t       head;
  ent_t       push_ent;
  logic [1:0] occ;
  logic       exu_vld, xfer, redir, push, pop;
  logic       fetch_vld, fetch_hs;
  logic [2:0] occ_proj;

  assign exu_vld = ~rst & (occ != 2'd0);
  assign xfer    = exu_vld & iexec.req_rdy;
  assign redir   = xfer & iexec.rsp_pkt.taken;
  assign pop     = xfer & ~iexec.rsp_pkt.taken;
  assign push    = (state_q == WAIT) & ifetch.rsp_vld;

  // Buffer level once this cycle's pop and the in-flight word are counted;
  // a new fetch is only allowed while that still leaves a free slot.
  assign occ_proj  = {1'b0, occ} + {2'b00, state_q == WAIT} - {2'b00, xfer};
  assign fetch_vld = ~rst & ~redir & (state_q != DROP) &
                     ((state_q == IDLE) | ifetch.rsp_vld) & (occ_proj < 3'd2);
  assign fetch_hs  = fetch_vld & ifetch.req_rdy;

  assign push_ent.pc = out_pc_q;
  assign push_ent.ir = ifetch.rsp_data;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_pc_d   = out_pc_q;
    if (fetch_hs) begin
      out_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + AW'(ILEN_BYTES);
    end
    if (redir) fetch_pc_d = head.pc + iexec.rsp_pkt.offset;
    case (state_q)
      IDLE: if (fetch_hs) state_d = WAIT;
      WAIT: begin
        if (ifetch.rsp_vld)  state_d = fetch_hs ? WAIT : IDLE;
        else if (redir)      state_d = DROP;
      end
      DROP: if (ifetch.rsp_vld) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RST_PC;
      out_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_pc_q   <= out_pc_d;
    end
  end

  ifu_ibuf #(
    .ENT_T (ent_t)
  ) u_ibuf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_ent_i (push_ent),
    .pop_i      (pop),
    .flush_i    (redir),
    .head_o     (head),
    .occ_o      (occ)
  );

  assign ifetch.req_vld    = fetch_vld;
  assign ifetch.req_addr   = fetch_pc_q;
  assign iexec.req_vld     = exu_vld;
  assign iexec.req_pkt.pc  = head.pc;
  assign iexec.req_pkt.ir  = head.ir;

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// +---------------------------------------------------------------+
// | tb_ifu -- directed and random bench with a program-order model |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
module tb_ifu;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_if_t #(.AW(32), .DW(32)) fbus ();
  iexec_if_t  #(.AW(32), .DW(32)) xbus ();

  ifu #(.AW(32), .DW(32), .RST_PC(RST_PC)) dut (
    .clk    (clk),
    .rst    (rst),
    .ifetch (fbus),
    .iexec  (xbus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // stimulus knobs, applied at the next falling edge
  logic        rst_cmd;
  int          exu_mode;      // 0 stalled, 1 ready, 2 random
  logic        mem_rand_rdy, mem_rand_lat, hold_mem, rand_br;
  int          mem_lat;
  logic [31:0] br_pc  [4];
  logic [31:0] br_off [4];
  int          br_n;

  // memory model: one word in flight at most
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_rsp_cyc;

  // architectural reference: next pc in program order
  logic [31:0] exp_pc, pend_tgt;
  logic        pend_vld;
  int          n_deliv;

  logic        o_fvld, o_fhs, o_xvld, o_xfer, o_redir;
  logic [31:0] o_faddr, o_xpc, o_xir;
  logic        p_stall;
  logic [31:0] p_pc, p_ir;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_965A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
  endtask

  task automatic cycle();
    logic        tk;
    logic [31:0] off;
    @(negedge clk);
    rst = rst_cmd;
    fbus.rsp_vld  = mem_busy && (cyc == mem_rsp_cyc);
    fbus.rsp_data = fbus.rsp_vld ? memw(mem_addr) : $urandom;
    fbus.req_rdy  = hold_mem ? 1'b0 : (mem_rand_rdy ? ($urandom_range(3) != 0) : 1'b1);
    case (exu_mode)
      0:       xbus.req_rdy = 1'b0;
      1:       xbus.req_rdy = 1'b1;
      default: xbus.req_rdy = ($urandom_range(9) < 7);
    endcase
    tk  = 1'b0;
    off = $urandom;
    for (int i = 0; i < br_n; i++)
      if (xbus.req_pkt.pc == br_pc[i]) begin
        tk  = 1'b1;
        off = br_off[i];
      end
    if (rand_br && $urandom_range(4) == 0) begin
      tk  = 1'b1;
      off = 32'($urandom_range(64)) * 32'd4 - 32'd128;
    end
    xbus.rsp_pkt.taken  = tk;
    xbus.rsp_pkt.offset = off;
    #1;
    o_fvld  = fbus.req_vld;
    o_faddr = fbus.req_addr;
    o_fhs   = fbus.req_vld & fbus.req_rdy;
    o_xvld  = xbus.req_vld;
    o_xfer  = xbus.req_vld & xbus.req_rdy;
    o_redir = o_xfer & tk;
    o_xpc   = xbus.req_pkt.pc;
    o_xir   = xbus.req_pkt.ir;

    if (rst) begin
      chk("rst_fetch_vld", {31'd0, o_fvld}, 32'd0);
      chk("rst_exec_vld", {31'd0, o_xvld}, 32'd0);
      exp_pc   = RST_PC;
      pend_vld = 1'b0;
    end
    if (p_stall && !rst) begin
      chk("stall_vld", {31'd0, o_xvld}, 32'd1);
      chk("stall_pc", o_xpc, p_pc);
      chk("stall_ir", o_xir, p_ir);
    end
    if (o_xfer) begin
      chk("exec_pc", o_xpc, exp_pc);
      chk("exec_ir", o_xir, memw(exp_pc));
      n_deliv++;
      exp_pc = tk ? exp_pc + off : exp_pc + 32'd4;
      if (tk) begin
        chk("no_fetch_on_redirect", {31'd0, o_fvld}, 32'd0);
        pend_vld = 1'b1;
        pend_tgt = exp_pc;
      end
    end
    if (fbus.rsp_vld) mem_busy = 1'b0;
    if (o_fhs) begin
      chk("single_outstanding", {31'd0, mem_busy}, 32'd0);
      if (pend_vld) begin
        chk("redirect_target", o_faddr, pend_tgt);
        pend_vld = 1'b0;
      end
      mem_busy    = 1'b1;
      mem_addr    = o_faddr;
      mem_rsp_cyc = cyc + (mem_rand_lat ? $urandom_range(3, 1) : mem_lat);
    end
    p_stall = !rst && o_xvld && !xbus.req_rdy;
    p_pc    = o_xpc;
    p_ir    = o_xir;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst_cmd = 1'b1;
    repeat (n) cycle();
    rst_cmd = 1'b0;
  endtask

  task automatic wait_redir(input string tag);
    int k = 0;
    do begin
      cycle();
      k++;
    end while (!o_redir && k < 40);
    chk(tag, {31'd0, o_redir}, 32'd1);
  endtask

  task automatic wait_xfer(input string tag, input logic [31:0] want_pc);
    int k = 0;
    do begin
      cycle();
      k++;
    end while (!o_xfer && k < 40);
    chk({tag, "_seen"}, {31'd0, o_xfer}, 32'd1);
    chk(tag, o_xpc, want_pc);
  endtask

  initial begin
    int n_fh;
    int d0;
    rst = 1'b1;
    fbus.req_rdy = 1'b0; fbus.rsp_vld = 1'b0; fbus.rsp_data = '0;
    xbus.req_rdy = 1'b0; xbus.rsp_pkt = '0;
    rst_cmd = 1'b1; exu_mode = 1; mem_rand_rdy = 1'b0; mem_rand_lat = 1'b0;
    hold_mem = 1'b0; rand_br = 1'b0; mem_lat = 1; br_n = 0;
    mem_busy = 1'b0; mem_addr = '0; mem_rsp_cyc = 0;
    exp_pc = RST_PC; pend_vld = 1'b0; pend_tgt = '0; n_deliv = 0;
    p_stall = 1'b0; p_pc = '0; p_ir = '0;

    // reset release, 1-cycle memory, streaming at one per cycle
    do_reset(3);
    cycle();
    chk("first_fetch_hs", {31'd0, o_fhs}, 32'd1);
    chk("first_fetch_addr", o_faddr, RST_PC);
    chk("first_exec_vld", {31'd0, o_xvld}, 32'd0);
    cycle();
    chk("fetch1_addr", o_faddr, 32'h104);
    chk("exec_vld_cycle1", {31'd0, o_xvld}, 32'd0);
    cycle();
    chk("fetch2_addr", o_faddr, 32'h108);
    chk("exec_vld_cycle2", {31'd0, o_xvld}, 32'd1);
    chk("exec_pc_cycle2", o_xpc, 32'h100);
    repeat (6) begin
      cycle();
      chk("throughput_xfer", {31'd0, o_xfer}, 32'd1);
      chk("throughput_fetch", {31'd0, o_fhs}, 32'd1);
    end

    // redirect in the same cycle as the response
    do_reset(4);
    br_pc[0] = 32'h108; br_off[0] = 32'h10; br_n = 1;
    wait_redir("redir_same_cycle_seen");
    br_n = 0;
    cycle();
    chk("same_cycle_next_fetch", {31'd0, o_fhs}, 32'd1);
    chk("same_cycle_next_addr", o_faddr, 32'h118);
    wait_xfer("same_cycle_target_pc", 32'h118);

    // redirect with a live fetch outstanding: stale word dropped
    do_reset(4);
    mem_lat = 2;
    br_pc[0] = 32'h108; br_off[0] = 32'h10; br_n = 1;
    wait_redir("redir_drop_seen");
    br_n = 0;
    cycle();
    chk("drop_no_fetch", {31'd0, o_fvld}, 32'd0);
    cycle();
    chk("drop_next_fetch", {31'd0, o_fhs}, 32'd1);
    chk("drop_next_addr", o_faddr, 32'h118);
    wait_xfer("drop_target_pc", 32'h118);

    // negative offset and address wrap
    do_reset(4);
    mem_lat = 1;
    br_pc[0] = 32'h104; br_off[0] = 32'hFFFF_FF04;
    br_pc[1] = 32'h008; br_off[1] = 32'hFFFF_FFF0; br_n = 2;
    wait_redir("wrap_redir1_seen");
    wait_redir("wrap_redir2_seen");
    br_n = 0;
    cycle();
    chk("wrap_fetch_f8", o_faddr, 32'hFFFF_FFF8);
    cycle();
    chk("wrap_fetch_fc", o_faddr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_fetch_0", o_faddr, 32'h0);
    repeat (6) cycle();

    // EXU stalled: buffer fills with two words, nothing outstanding
    do_reset(4);
    exu_mode = 0;
    n_fh = 0;
    repeat (10) begin
      cycle();
      if (o_fhs) n_fh++;
    end
    chk("stall_fetch_count", n_fh, 32'd2);
    chk("stall_outstanding", {31'd0, mem_busy}, 32'd0);
    chk("stall_fetch_vld", {31'd0, o_fvld}, 32'd0);
    chk("stall_head_pc", o_xpc, 32'h100);
    exu_mode = 1;
    cycle();
    chk("release_fetch", {31'd0, o_fhs}, 32'd1);
    chk("release_addr", o_faddr, 32'h108);
    repeat (5) begin
      cycle();
      chk("release_stream", {31'd0, o_xfer}, 32'd1);
    end

    // reset with a fetch in flight; its late response must be ignored
    mem_lat = 3;
    n_fh = 0;
    do begin
      cycle();
      n_fh++;
    end while (!o_fhs && n_fh < 20);
    chk("pre_reset_fetch_seen", {31'd0, o_fhs}, 32'd1);
    exu_mode = 0;
    rst_cmd = 1'b1;
    cycle();
    cycle();
    rst_cmd  = 1'b0;
    hold_mem = 1'b1;
    cycle();
    chk("post_rst_fetch_vld", {31'd0, o_fvld}, 32'd1);
    chk("post_rst_fetch_addr", o_faddr, RST_PC);
    hold_mem = 1'b0;
    cycle();
    chk("late_rsp_ignored", {31'd0, o_xvld}, 32'd0);
    chk("restart_fetch_addr", o_faddr, RST_PC);
    chk("restart_fetch_hs", {31'd0, o_fhs}, 32'd1);
    exu_mode = 1;
    wait_xfer("restart_first_pc", RST_PC);

    // random traffic against the program-order model
    do_reset(4);
    mem_rand_rdy = 1'b1; mem_rand_lat = 1'b1; exu_mode = 2; rand_br = 1'b1;
    d0 = n_deliv;
    repeat (3000) cycle();
    chk("random_progress", {31'd0, (n_deliv - d0) > 300}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
